// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus an iterative shift-add multiply.
// One operation in flight; result and flags are registered and held until taken.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_control_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             v_flag,
  output logic             n_flag,
  output logic             z_flag,
  output logic             c_flag,
  output logic             illegal,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t            state_q;
  logic [SH_W-1:0]   cnt_q;
  logic [WIDTH-1:0]  acc_q, mcand_q, mplier_q;
  logic [WIDTH-1:0]  result_q;
  logic              v_q, n_q, z_q, c_q, ill_q, out_valid_q;

  logic signed [WIDTH-1:0] op1_s, op2_s;
  logic [WIDTH:0]          sum_c, dif_c;
  logic [SH_W-1:0]         shamt;
  logic [WIDTH-1:0]        res_c;
  logic                    v_c, c_c, ill_c, is_mul_c, accept;

  assign op1_s  = op1;
  assign op2_s  = op2;
  assign shamt  = op2[SH_W-1:0];
  assign sum_c  = {1'b0, op1} + {1'b0, op2};
  // Subtract as op1 + ~op2 + 1 so the carry-out is directly NOT borrow.
  assign dif_c  = {1'b0, op1} + {1'b0, ~op2} + {{WIDTH{1'b0}}, 1'b1};

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    res_c    = '0;
    v_c      = 1'b0;
    c_c      = 1'b0;
    ill_c    = 1'b0;
    is_mul_c = 1'b0;
    case (alu_control_code)
      OP_AND:  res_c = op1 & op2;
      OP_OR:   res_c = op1 | op2;
      OP_NOR:  res_c = ~(op1 | op2);
      OP_NAND: res_c = ~(op1 & op2);
      OP_XOR:  res_c = op1 ^ op2;
      OP_ADD: begin
        res_c = sum_c[WIDTH-1:0];
        c_c   = sum_c[WIDTH];
        v_c   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum_c[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = dif_c[WIDTH-1:0];
        c_c   = dif_c[WIDTH];
        v_c   = (op1[WIDTH-1] != op2[WIDTH-1]) && (dif_c[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, (op1_s < op2_s)};
      OP_SLL:  res_c = op1 << shamt;
      OP_SRL:  res_c = op1 >> shamt;
      OP_SRA:  res_c = op1_s >>> shamt;
      OP_MUL: begin
        if (MUL_EN) is_mul_c = 1'b1;
        else        ill_c    = 1'b1;
      end
      default: ill_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_mul_c) begin
              state_q  <= S_MUL;
              cnt_q    <= '0;
              acc_q    <= '0;
              mcand_q  <= op1;
              mplier_q <= op2;
            end else begin
              result_q    <= res_c;
              v_q         <= v_c;
              c_q         <= c_c;
              n_q         <= res_c[WIDTH-1];
              // An illegal op reports result 0 with every flag clear, including z.
              z_q         <= !ill_c && (res_c == '0);
              ill_q       <= ill_c;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SH_W'(1);
          if (cnt_q == SH_W'(WIDTH - 1)) state_q <= S_DONE;
        end
        S_DONE: begin
          result_q    <= acc_q;
          v_q         <= 1'b0;
          c_q         <= 1'b0;
          n_q         <= acc_q[WIDTH-1];
          z_q         <= (acc_q == '0);
          ill_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign v_flag    = v_q;
  assign n_flag    = n_q;
  assign z_flag    = z_q;
  assign c_flag    = c_q;
  assign illegal   = ill_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 32-bit instance checked through a result scoreboard, and an
// 8-bit instance without the multiplier checked inline.
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] r;
    logic        v, n, z, c, ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [31:0] op1, op2;
  logic [3:0]  code;
  logic        in_ready, out_valid, v_flag, n_flag, z_flag, c_flag, illegal, busy;
  logic [31:0] result;

  logic        in_valid8, out_ready8;
  logic [7:0]  op1_8, op2_8;
  logic [3:0]  code8;
  logic        in_ready8, out_valid8, v8, n8, z8, c8, ill8, busy8;
  logic [7:0]  result8;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_control_code(code), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .v_flag(v_flag), .n_flag(n_flag),
    .z_flag(z_flag), .c_flag(c_flag), .illegal(illegal), .busy(busy)
  );

  alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .op1(op1_8), .op2(op2_8), .alu_control_code(code8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .v_flag(v8), .n_flag(n8),
    .z_flag(z8), .c_flag(c8), .illegal(ill8), .busy(busy8)
  );

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sl;
    logic [63:0] p;
    e  = '0;
    sl = 0;
    p  = '0;
    case (op)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b1001: e.r = ~(a | b);
      4'b1100: e.r = ~(a & b);
      4'b1101: e.r = a ^ b;
      4'b0010: begin
        p   = {32'b0, a} + {32'b0, b};
        e.r = p[31:0];
        e.c = p[32];
        sl  = longint'($signed(a)) + longint'($signed(b));
        e.v = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
      end
      4'b0110: begin
        e.r = a - b;
        e.c = (a >= b);
        sl  = longint'($signed(a)) - longint'($signed(b));
        e.v = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
      end
      4'b0111: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: e.r = a << b[4:0];
      4'b0100: e.r = a >> b[4:0];
      4'b0101: e.r = $signed(a) >>> b[4:0];
      4'b1000: begin
        p   = {32'b0, a} * {32'b0, b};
        e.r = p[31:0];
      end
      default: e.ill = 1'b1;
    endcase
    e.n = e.r[31] && !e.ill;
    e.z = (e.r == 32'd0) && !e.ill;
    return e;
  endfunction

  // Scoreboard: every result taken by the consumer is matched against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_unexpected: got result=%h with no pending expectation", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({result, v_flag, n_flag, z_flag, c_flag, illegal} !== e)
          $display("FAIL scoreboard: got r=%h v=%b n=%b z=%b c=%b ill=%b, expected r=%h v=%b n=%b z=%b c=%b ill=%b",
                   result, v_flag, n_flag, z_flag, c_flag, illegal, e.r, e.v, e.n, e.z, e.c, e.ill);
        else n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    in_valid = 1'b1;
    code     = op;
    op1      = a;
    op2      = b;
    #1;
    for (int i = 0; i < 100 && !in_ready; i++) step();
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 100 cycles", in_ready);
    end
    if (push) exp_q.push_back(model(op, a, b));
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; op1 = '0; op2 = '0; code = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; op1_8 = '0; op2_8 = '0; code8 = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    n_total++;
    if ({out_valid, busy, in_ready, illegal} !== 4'b0010)
      $display("FAIL reset_ctrl: got ov/busy/rdy/ill=%b%b%b%b, required 0010", out_valid, busy, in_ready, illegal);
    else n_pass++;
    n_total++;
    if ({result, v_flag, n_flag, z_flag, c_flag} !== 36'd0)
      $display("FAIL reset_data: got r=%h flags=%b%b%b%b, required all zero", result, v_flag, n_flag, z_flag, c_flag);
    else n_pass++;
  endtask

  task automatic test_logic();
    send(4'b0000, 32'h000000ff, 32'h00000f0f, 1'b1);
    n_total++;
    if (out_valid !== 1'b1 || result !== 32'h0000000f || z_flag !== 1'b0)
      $display("FAIL and_latency: got ov=%b r=%h z=%b, required ov=1 r=0000000f z=0", out_valid, result, z_flag);
    else n_pass++;
    send(4'b1001, 32'h000000ff, 32'h00000f0f, 1'b1);
    n_total++;
    if (result !== 32'hfffff000 || n_flag !== 1'b1)
      $display("FAIL nor_result: got r=%h n=%b, required r=fffff000 n=1", result, n_flag);
    else n_pass++;
    send(4'b1100, 32'hffff0000, 32'hff00ff00, 1'b1);
    send(4'b0001, 32'h12340000, 32'h00005678, 1'b1);
  endtask

  task automatic test_arith();
    step();
    send(4'b0010, 32'h7fffffff, 32'h00000001, 1'b1);
    send(4'b0010, 32'hffffffff, 32'h00000001, 1'b1);
    send(4'b0110, 32'd10, 32'd10, 1'b1);
    send(4'b0110, 32'hfffffff6, 32'd10, 1'b1);
    n_total++;
    if (result !== 32'hffffffec || c_flag !== 1'b1 || n_flag !== 1'b1)
      $display("FAIL sub_neg: got r=%h c=%b n=%b, required r=ffffffec c=1 n=1", result, c_flag, n_flag);
    else n_pass++;
    send(4'b0110, 32'h80000000, 32'h00000001, 1'b1);
    send(4'b0111, 32'hffffffff, 32'h00000001, 1'b1);
    send(4'b0111, 32'h00000001, 32'hffffffff, 1'b1);
  endtask

  task automatic test_mul();
    int bad;
    bad = 0;
    step();
    send(4'b1000, 32'd7, 32'hfffffffd, 1'b1);
    for (int i = 0; i < 33; i++) begin
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) bad++;
      step();
    end
    n_total++;
    if (bad != 0) $display("FAIL mul_busy_window: %0d cycles out of 33 wrong, required 0", bad);
    else n_pass++;
    n_total++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || result !== 32'hffffffeb || n_flag !== 1'b1 || v_flag !== 1'b0)
      $display("FAIL mul_done: got ov=%b busy=%b r=%h n=%b v=%b, required 1 0 ffffffeb 1 0",
               out_valid, busy, result, n_flag, v_flag);
    else n_pass++;
    send(4'b1000, 32'h0001_0003, 32'h0002_0005, 1'b1);
    for (int i = 0; i < 40 && !out_valid; i++) step();
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int          bad;
    bad = 0;
    step();
    step();
    out_ready = 1'b0;
    send(4'b0010, 32'd5, 32'd6, 1'b1);
    held = result;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0) bad++;
      step();
    end
    n_total++;
    if (bad != 0 || held !== 32'd11)
      $display("FAIL backpressure_hold: %0d bad cycles, held=%h, required 0 bad and held=0000000b", bad, held);
    else n_pass++;
    out_ready = 1'b1;
    send(4'b1101, 32'hf0f0f0f0, 32'hff00ff00, 1'b1);
    n_total++;
    if (out_valid !== 1'b1 || result !== 32'h0ff00ff0)
      $display("FAIL xor_after_stall: got ov=%b r=%h, required ov=1 r=0ff00ff0", out_valid, result);
    else n_pass++;
  endtask

  task automatic test_shift_illegal();
    step();
    send(4'b0101, 32'h80000000, 32'h00000024, 1'b1);
    send(4'b0100, 32'h80000000, 32'h00000024, 1'b1);
    send(4'b0011, 32'h0000_00f1, 32'h0000_0023, 1'b1);
    send(4'b0011, 32'hdeadbeef, 32'h00000020, 1'b1);
    n_total++;
    if (result !== 32'hdeadbeef)
      $display("FAIL sll_zero_shamt: got r=%h, required deadbeef", result);
    else n_pass++;
    send(4'b1111, 32'h12345678, 32'h9abcdef0, 1'b1);
    n_total++;
    if (illegal !== 1'b1 || result !== 32'd0 || z_flag !== 1'b0)
      $display("FAIL illegal_op: got ill=%b r=%h z=%b, required ill=1 r=0 z=0", illegal, result, z_flag);
    else n_pass++;
    send(4'b1010, 32'h1, 32'h1, 1'b1);
    send(4'b0101, 32'h40000000, 32'h0000001f, 1'b1);
  endtask

  task automatic test_reset_abort();
    step();
    step();
    send(4'b1000, 32'd3, 32'd9, 1'b0);
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_mid_mul: got ov=%b busy=%b rdy=%b, required 0 0 1", out_valid, busy, in_ready);
    else n_pass++;
  endtask

  task automatic test_mul_disabled();
    in_valid8 = 1'b1; code8 = 4'b1000; op1_8 = 8'd3; op2_8 = 8'd5;
    #1;
    n_total++;
    if (in_ready8 !== 1'b1) $display("FAIL w8_ready: got %b, required 1", in_ready8);
    else n_pass++;
    step();
    n_total++;
    if ({out_valid8, ill8, result8, v8, n8, z8, c8, busy8} !== {2'b11, 8'h00, 5'b00000})
      $display("FAIL w8_mul_illegal: got ov=%b ill=%b r=%h vnzc=%b%b%b%b busy=%b, required ov=1 ill=1 r=00 flags 0 busy=0",
               out_valid8, ill8, result8, v8, n8, z8, c8, busy8);
    else n_pass++;
    code8 = 4'b0010; op1_8 = 8'hff; op2_8 = 8'h01;
    step();
    n_total++;
    if ({result8, z8, c8, v8, ill8} !== {8'h00, 4'b1100})
      $display("FAIL w8_add_wrap: got r=%h z=%b c=%b v=%b ill=%b, required r=00 z=1 c=1 v=0 ill=0",
               result8, z8, c8, v8, ill8);
    else n_pass++;
    code8 = 4'b0101; op1_8 = 8'h80; op2_8 = 8'h0b;
    step();
    in_valid8 = 1'b0;
    n_total++;
    if (result8 !== 8'hf0 || n8 !== 1'b1)
      $display("FAIL w8_sra: got r=%h n=%b, required r=f0 n=1", result8, n8);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_logic();
    test_arith();
    test_mul();
    test_backpressure();
    test_shift_illegal();
    test_reset_abort();
    test_mul_disabled();
    step();
    step();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d results still pending, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
